// File: rtl/alu_ctrl_mc.sv
// ALU control unit with a multi-cycle sequencer: decodes funct/ALU-class into an
// ALU operation code and holds the ALU busy for the configured MULT/DIV latency.
module alu_ctrl_mc #(
  parameter int         MUL_LAT      = 4,
  parameter int         DIV_LAT      = 8,
  parameter logic [2:0] ILLEGAL_CODE = 3'b111
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [5:0] Itr,
  input  logic [2:0] OpA,
  input  logic       flush,
  output logic [2:0] IA,
  output logic       out_valid,
  output logic       busy,
  output logic       err
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT) + 1;

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_MULDIV = 2'b01,
    S_DONE   = 2'b10
  } state_t;

  typedef struct packed {
    logic [2:0] code;
    logic       illegal;
    logic       is_mul;
    logic       is_div;
  } dec_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]       r_ia, w_ia_nxt;
  logic             r_err, w_err_nxt;
  dec_t             w_dec;
  logic             w_accept;

  // Decoder: anything not in the table falls through to the illegal default,
  // so the code is always a defined value.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    w_dec.code    = ILLEGAL_CODE;
    w_dec.illegal = 1'b1;
    w_dec.is_mul  = 1'b0;
    w_dec.is_div  = 1'b0;
    unique case (OpA)
      3'b010: begin
        w_dec.illegal = 1'b0;
        unique case (Itr)
          6'b100000: w_dec.code = 3'b000;
          6'b100010: w_dec.code = 3'b001;
          6'b011000: begin
            w_dec.code   = 3'b010;
            w_dec.is_mul = 1'b1;
          end
          6'b011010: begin
            w_dec.code   = 3'b011;
            w_dec.is_div = 1'b1;
          end
          6'b100101: w_dec.code = 3'b100;
          6'b100100: w_dec.code = 3'b101;
          6'b101010: w_dec.code = 3'b110;
          6'b000000: w_dec.code = 3'b111;
          default: begin
            w_dec.code    = ILLEGAL_CODE;
            w_dec.illegal = 1'b1;
          end
        endcase
      end
      3'b011: begin
        w_dec.code    = 3'b000;
        w_dec.illegal = 1'b0;
      end
      3'b100: begin
        w_dec.code    = 3'b110;
        w_dec.illegal = 1'b0;
      end
      3'b101: begin
        w_dec.code    = 3'b101;
        w_dec.illegal = 1'b0;
      end
      3'b110: begin
        w_dec.code    = 3'b100;
        w_dec.illegal = 1'b0;
      end
      3'b001: begin
        w_dec.code    = 3'b001;
        w_dec.illegal = 1'b0;
      end
      default: begin
        w_dec.code    = ILLEGAL_CODE;
        w_dec.illegal = 1'b1;
      end
    endcase
  end

  // flush blocks acceptance even in IDLE, and masks the completion pulse in DONE.
  assign in_ready  = (r_state == S_IDLE) & ~flush;
  assign w_accept  = in_valid & in_ready;
  assign out_valid = (r_state == S_DONE) & ~flush;
  assign err       = out_valid & r_err;
  assign busy      = (r_state == S_MULDIV);
  assign IA        = r_ia;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ia_nxt    = r_ia;
    w_err_nxt   = r_err;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_ia_nxt  = w_dec.code;
          w_err_nxt = w_dec.illegal;
          if (w_dec.is_mul) begin
            w_state_nxt = S_MULDIV;
            w_cnt_nxt   = MUL_LOAD;
          end else if (w_dec.is_div) begin
            w_state_nxt = S_MULDIV;
            w_cnt_nxt   = DIV_LOAD;
          end else begin
            w_state_nxt = S_DONE;
          end
        end
      end
      S_MULDIV: begin
        if (flush || r_cnt == CNT_ONE) begin
          w_state_nxt = flush ? S_IDLE : S_DONE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt - CNT_ONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_ia    <= 3'b000;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ia    <= w_ia_nxt;
      r_err   <= w_err_nxt;
    end
  end

endmodule

// File: tb/tb_alu_ctrl_mc.sv
// Self-checking bench for alu_ctrl_mc: directed scenarios plus random traffic,
// compared each cycle against a transaction-level reference model.
module tb_alu_ctrl_mc;

  localparam int         MUL_LAT = 4;
  localparam int         DIV_LAT = 8;
  localparam logic [2:0] ILLEGAL = 3'b111;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [5:0] Itr;
  logic [2:0] OpA;
  logic       flush;
  logic [2:0] IA;
  logic       out_valid;
  logic       busy;
  logic       err;

  alu_ctrl_mc #(
    .MUL_LAT     (MUL_LAT),
    .DIV_LAT     (DIV_LAT),
    .ILLEGAL_CODE(ILLEGAL)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .Itr      (Itr),
    .OpA      (OpA),
    .flush    (flush),
    .IA       (IA),
    .out_valid(out_valid),
    .busy     (busy),
    .err      (err)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  // Reference model: one outstanding operation, completing LAT cycles after the
  // cycle in which it was presented.
  bit         m_pending;
  int         m_done;
  int         cyc;
  logic [2:0] m_ia;
  bit         m_err;

  logic [5:0] legal_itr [8]  = '{6'b100000, 6'b100010, 6'b011000, 6'b011010,
                                 6'b100101, 6'b100100, 6'b101010, 6'b000000};
  logic [2:0] sw_opa    [13] = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b010, 3'b010, 3'b010,
                                 3'b010, 3'b011, 3'b100, 3'b101, 3'b110, 3'b001};
  logic [5:0] sw_itr    [13] = '{6'b100000, 6'b100010, 6'b011000, 6'b011010, 6'b100101,
                                 6'b100100, 6'b101010, 6'b000000, 6'b000000, 6'b000000,
                                 6'b000000, 6'b000000, 6'b000000};
  logic [2:0] sw_ia     [13] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110,
                                 3'b111, 3'b000, 3'b110, 3'b101, 3'b100, 3'b001};

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic void ref_decode(input logic [2:0] opa, input logic [5:0] itr,
                                     output logic [2:0] code, output bit bad,
                                     output int lat);
    bad  = 1'b0;
    lat  = 1;
    code = ILLEGAL;
    case (opa)
      3'b010: begin
        case (itr)
          6'b100000: code = 3'b000;
          6'b100010: code = 3'b001;
          6'b011000: begin code = 3'b010; lat = MUL_LAT; end
          6'b011010: begin code = 3'b011; lat = DIV_LAT; end
          6'b100101: code = 3'b100;
          6'b100100: code = 3'b101;
          6'b101010: code = 3'b110;
          6'b000000: code = 3'b111;
          default:   bad = 1'b1;
        endcase
      end
      3'b011:  code = 3'b000;
      3'b100:  code = 3'b110;
      3'b101:  code = 3'b101;
      3'b110:  code = 3'b100;
      3'b001:  code = 3'b001;
      default: bad = 1'b1;
    endcase
    if (bad) code = ILLEGAL;
  endfunction

  task automatic model_reset();
    m_pending = 1'b0;
    m_ia      = 3'b000;
    m_err     = 1'b0;
  endtask

  // One clock cycle: drive inputs, compare all outputs, advance the model, step the edge.
  task automatic cycle(input bit iv, input logic [2:0] opa, input logic [5:0] itr,
                       input bit fl);
    bit         ov;
    logic [2:0] code;
    bit         bad;
    int         lat;
    in_valid = iv;
    OpA      = opa;
    Itr      = itr;
    flush    = fl;
    #1;
    ov = m_pending && (cyc == m_done) && !fl;
    check("in_ready",  {7'd0, in_ready},  {7'd0, !m_pending && !fl});
    check("out_valid", {7'd0, out_valid}, {7'd0, ov});
    check("busy",      {7'd0, busy},      {7'd0, m_pending && (cyc < m_done)});
    check("err",       {7'd0, err},       {7'd0, ov && m_err});
    check("IA",        {5'd0, IA},        {5'd0, m_ia});
    if (fl) begin
      m_pending = 1'b0;
    end else if (m_pending) begin
      if (cyc == m_done) m_pending = 1'b0;
    end else if (iv) begin
      ref_decode(opa, itr, code, bad, lat);
      m_pending = 1'b1;
      m_done    = cyc + lat;
      m_ia      = code;
      m_err     = bad;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain(input string tag);
    int k = 0;
    while (m_pending && k < 20) begin
      cycle(1'b0, 3'b000, 6'b000000, 1'b0);
      k++;
    end
    check(tag, {7'd0, m_pending}, 8'd0);
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    cyc      = 0;
    m_done   = 0;
    model_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    OpA      = 3'b000;
    Itr      = 6'b000000;
    flush    = 1'b0;
    #3;
    check("rst_IA",        {5'd0, IA},        8'd0);
    check("rst_busy",      {7'd0, busy},      8'd0);
    check("rst_out_valid", {7'd0, out_valid}, 8'd0);
    check("rst_err",       {7'd0, err},       8'd0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // SUB presented in the first cycle after reset release.
    cycle(1'b1, 3'b010, 6'b100010, 1'b0);
    check("sub_IA", {5'd0, IA}, 8'h01);
    drain("sub_drain");

    // DIV, with ignored in_valid traffic while the ALU is occupied.
    cycle(1'b1, 3'b010, 6'b011010, 1'b0);
    check("div_IA", {5'd0, IA}, 8'h03);
    for (int i = 0; i < 4; i++) cycle(1'b1, 3'b011, 6'b000000, 1'b0);
    drain("div_drain");

    // Illegal class, then ANDI.
    cycle(1'b1, 3'b111, 6'b000000, 1'b0);
    check("ill_IA", {5'd0, IA}, {5'd0, ILLEGAL});
    drain("ill_drain");
    cycle(1'b1, 3'b101, 6'b000000, 1'b0);
    check("andi_IA", {5'd0, IA}, 8'h05);
    drain("andi_drain");

    // Unlisted funct with R-type class.
    cycle(1'b1, 3'b010, 6'b111111, 1'b0);
    drain("badfn_drain");

    // MULT flushed in its second busy cycle.
    cycle(1'b1, 3'b010, 6'b011000, 1'b0);
    cycle(1'b0, 3'b000, 6'b000000, 1'b0);
    cycle(1'b0, 3'b000, 6'b000000, 1'b1);
    check("flush_IA", {5'd0, IA}, 8'h02);
    for (int i = 0; i < 5; i++) cycle(1'b0, 3'b000, 6'b000000, 1'b0);

    // Flush during the DONE cycle, then flush racing in_valid in IDLE.
    cycle(1'b1, 3'b110, 6'b000000, 1'b0);
    cycle(1'b0, 3'b000, 6'b000000, 1'b1);
    cycle(1'b1, 3'b010, 6'b100000, 1'b1);
    cycle(1'b0, 3'b000, 6'b000000, 1'b0);
    check("flushwin_IA", {5'd0, IA}, 8'h04);

    // Asynchronous reset in the middle of a MULT.
    cycle(1'b1, 3'b010, 6'b011000, 1'b0);
    cycle(1'b0, 3'b000, 6'b000000, 1'b0);
    rst_n = 1'b0;
    #2;
    check("arst_busy",      {7'd0, busy},      8'd0);
    check("arst_IA",        {5'd0, IA},        8'd0);
    check("arst_out_valid", {7'd0, out_valid}, 8'd0);
    model_reset();
    @(posedge clk);
    #1;
    cyc++;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) cycle(1'b0, 3'b000, 6'b000000, 1'b0);

    // Back-to-back sweep of every legal code.
    for (int i = 0; i < 13; i++) begin
      cycle(1'b1, sw_opa[i], sw_itr[i], 1'b0);
      check($sformatf("sweep_IA_%0d", i), {5'd0, IA}, {5'd0, sw_ia[i]});
      drain($sformatf("sweep_drain_%0d", i));
    end

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      bit         iv;
      bit         fl;
      logic [2:0] opa;
      logic [5:0] itr;
      iv  = ($urandom_range(0, 1) == 1);
      fl  = ($urandom_range(0, 15) == 0);
      opa = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) itr = legal_itr[$urandom_range(0, 7)];
      else                           itr = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 1) == 1) opa = 3'b010;
      cycle(iv, opa, itr, fl);
    end
    drain("final_drain");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
